hazard_unit: RTL and testbench
==============================

# hazard_unit

Central hazard controller that drives the stall/flush pair of every pipeline register (pc, i2d, d2e, e2m, m2w). It resolves d-cache miss, branch mispredict, load-use and i-cache miss hazards by fixed priority. A small recovery FSM blanks the fetch slot while the synchronous i-cache refetches from the redirected PC. Per-cause saturating stall counters are provided for performance analysis.

## Interface
- REDIRECT_CYCLES, default 1: cycles of forced i2d flush after a mispredict (0 = none); legal range 0..15.
- CNT_W, default 32: width of each performance counter.

- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low; clock clk
- ic_miss  in  1  fetch output not valid this cycle
- dc_miss  in  1  d-cache cannot complete the MEM-stage access this cycle
- ex_mispredict  in  1  valid branch in EX resolved opposite to prediction
- ex_valid  in  1  EX holds a real instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rw_addr  in  5  EX destination register
- dec_valid  in  1  decode holds a real instruction
- dec_uses_rs / dec_uses_rt  in  1 each  decode reads rs / rt
- dec_rs_addr / dec_rt_addr  in  5 each  decode source registers
- clr_cnt  in  1  synchronous clear of all counters
- pc_stall  out  1  hold PC
- i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, e2m_flush, m2w_stall, m2w_flush  out  1 each  per-register controls
- cnt_dc, cnt_ic, cnt_lu, cnt_mp  out  CNT_W each  cycles won by each cause

## Operation
- load_use = ex_valid & ex_is_load & (ex_rw_addr != 0) & dec_valid & ((dec_uses_rs & dec_rs_addr == ex_rw_addr) | (dec_uses_rt & dec_rt_addr == ex_rw_addr)).
- Default: all stall and flush outputs 0.
- Priority, first match wins:
  1. dc_miss: pc_stall, i2d_stall, d2e_stall, e2m_stall = 1; m2w_flush = 1. FSM and its counter are frozen.
  2. ex_mispredict: i2d_flush = d2e_flush = 1; pc not stalled. FSM enters RECOVER with rcnt = REDIRECT_CYCLES; stays IDLE if REDIRECT_CYCLES = 0. A mispredict while in RECOVER reloads rcnt.
  3. State RECOVER: i2d_flush = 1; pc_stall = ic_miss. load_use is ignored. rcnt decrements only when !ic_miss; the FSM returns to IDLE on the cycle rcnt decrements from 1 to 0.
  4. load_use: pc_stall = i2d_stall = 1; d2e_flush = 1.
  5. ic_miss: pc_stall = 1; i2d_flush = 1.
- Stall and flush are never both 1 on the same register.
- FSM states: IDLE, RECOVER. rcnt is 4 bits.
- Counters:
  - cnt_dc increments on cycles where cause 1 wins.
  - cnt_mp increments on cycles where cause 2 wins.
  - cnt_lu increments on cycles where cause 4 wins.
  - cnt_ic increments on cycles where cause 5 wins, or where RECOVER is active with ic_miss = 1.
  - Each counter saturates at all-ones.
  - clr_cnt zeroes all counters and takes precedence over increment.

## Timing
- All stall/flush outputs are combinational from the current inputs and registered state, with zero-cycle latency. The pipeline registers sample them at the next clk edge.
- FSM state, rcnt and counters update at posedge clk. Counter values are visible the cycle after the event.
- Reset (rst_n = 0 at posedge):
  - FSM = IDLE, rcnt = 0, all counters = 0.
  - While rst_n = 0, outputs are forced to: all stall = 0, all flush = 1.
- Reset during RECOVER aborts recovery; the first post-reset cycle is IDLE.
- dc_miss together with ex_mispredict: the stall wins. The mispredict is reconsidered in the cycle dc_miss drops, because EX was held.
- Mispredict on the last RECOVER cycle: rcnt reloads and the FSM stays in RECOVER.

## Test plan
- **Load-use:** EX lw to $t0 (8), dec_uses_rs with rs = 8 -> pc_stall = i2d_stall = d2e_flush = 1 for one cycle; cnt_lu = 1 next cycle. Repeat with ex_rw_addr = 0 -> no stall.
- **Mispredict + recovery:** ex_mispredict pulse with REDIRECT_CYCLES = 2 -> cycle 0: i2d_flush = d2e_flush = 1; cycles 1-2: i2d_flush only; cycle 3: IDLE, all outputs 0. With ic_miss held during cycle 1, recovery extends by one cycle and pc_stall = 1 on that cycle.
- **dc_miss priority:** dc_miss = 1 together with ex_mispredict and load_use for 3 cycles -> pc, i2d, d2e, e2m stall and m2w_flush each cycle; cnt_dc += 3, cnt_mp unchanged. On the 4th cycle, with dc_miss = 0, the mispredict flush occurs.
- **ic_miss alone:** ic_miss = 1 -> pc_stall = i2d_flush = 1, cnt_ic increments.
- **Counters:** set CNT_W = 4 and hold dc_miss for 20 cycles -> cnt_dc = 15 (saturated). Assert clr_cnt with dc_miss = 1 -> cnt_dc = 0 next cycle.
- **Reset:** assert rst_n = 0 mid-RECOVER -> all flush = 1, all stall = 0. After release the FSM is IDLE and counters read 0.

Source files
------------

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Purpose  : Central pipeline hazard controller. Generates the stall/flush
//            pair for every pipeline register (pc, i2d, d2e, e2m, m2w) by
//            resolving, in fixed priority order: d-cache miss, branch
//            mispredict, post-redirect recovery, load-use and i-cache miss.
//            A two-state recovery FSM blanks the fetch slot for
//            REDIRECT_CYCLES useful fetch cycles after a mispredict while
//            the synchronous i-cache refetches from the redirected PC.
//            Per-cause saturating counters record which cause won each cycle.
// Ports    :
//   clk, rst_n                 clock, synchronous active-low reset
//   ic_miss                    fetch output not valid this cycle
//   dc_miss                    MEM-stage d-cache access cannot complete
//   ex_mispredict              EX branch resolved against its prediction
//   ex_valid/ex_is_load/ex_rw_addr           EX instruction info
//   dec_valid/dec_uses_rs/dec_uses_rt/
//   dec_rs_addr/dec_rt_addr                  decode operand info
//   clr_cnt                    synchronous clear of all counters
//   pc_stall, *_stall, *_flush per-register pipeline controls
//   cnt_dc/cnt_ic/cnt_lu/cnt_mp cycles won by each hazard cause
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit #(
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ic_miss,
  input  logic             dc_miss,
  input  logic             ex_mispredict,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rw_addr,
  input  logic             dec_valid,
  input  logic             dec_uses_rs,
  input  logic             dec_uses_rt,
  input  logic [4:0]       dec_rs_addr,
  input  logic [4:0]       dec_rt_addr,
  input  logic             clr_cnt,
  output logic             pc_stall,
  output logic             i2d_stall,
  output logic             i2d_flush,
  output logic             d2e_stall,
  output logic             d2e_flush,
  output logic             e2m_stall,
  output logic             e2m_flush,
  output logic             m2w_stall,
  output logic             m2w_flush,
  output logic [CNT_W-1:0] cnt_dc,
  output logic [CNT_W-1:0] cnt_ic,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_mp
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RECOVER = 1'b1;

  localparam logic [3:0] c_redirect   = 4'(REDIRECT_CYCLES);
  localparam logic       c_has_redir  = (REDIRECT_CYCLES != 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [3:0]       rcnt_q,  rcnt_d;
  logic [CNT_W-1:0] cnt_dc_q, cnt_ic_q, cnt_lu_q, cnt_mp_q;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_load_use;

  // Register 0 is hard-wired zero, so a load targeting it never creates a
  // true dependency.
  assign w_rs_hit   = dec_uses_rs & (dec_rs_addr == ex_rw_addr);
  assign w_rt_hit   = dec_uses_rt & (dec_rt_addr == ex_rw_addr);
  assign w_load_use = ex_valid & ex_is_load & (ex_rw_addr != 5'd0) &
                      dec_valid & (w_rs_hit | w_rt_hit);

  // One-hot "who won this cycle" decode, in strict priority order.
  logic w_win_dc;
  logic w_win_mp;
  logic w_win_rec;
  logic w_win_lu;
  logic w_win_ic;

  assign w_win_dc  = dc_miss;
  assign w_win_mp  = ~dc_miss & ex_mispredict;
  assign w_win_rec = ~dc_miss & ~ex_mispredict & (state_q == RECOVER);
  assign w_win_lu  = ~dc_miss & ~ex_mispredict & (state_q != RECOVER) &
                     w_load_use;
  assign w_win_ic  = ~dc_miss & ~ex_mispredict & (state_q != RECOVER) &
                     ~w_load_use & ic_miss;

  // --------------------------------------------------------------------------
  // Stall / flush generation
  // --------------------------------------------------------------------------
  // While reset is held every pipeline register is flushed and nothing is
  // stalled, so the pipe drains to bubbles regardless of the other inputs.
  always_comb begin
    pc_stall  = 1'b0;
    i2d_stall = 1'b0;
    i2d_flush = 1'b0;
    d2e_stall = 1'b0;
    d2e_flush = 1'b0;
    e2m_stall = 1'b0;
    e2m_flush = 1'b0;
    m2w_stall = 1'b0;
    m2w_flush = 1'b0;

    if (!rst_n) begin
      i2d_flush = 1'b1;
      d2e_flush = 1'b1;
      e2m_flush = 1'b1;
      m2w_flush = 1'b1;
    end else if (w_win_dc) begin
      // Freeze everything up to MEM; inject a bubble into WB.
      pc_stall  = 1'b1;
      i2d_stall = 1'b1;
      d2e_stall = 1'b1;
      e2m_stall = 1'b1;
      m2w_flush = 1'b1;
    end else if (w_win_mp) begin
      // Kill the two wrong-path instructions younger than the branch; PC
      // is free to take the redirect.
      i2d_flush = 1'b1;
      d2e_flush = 1'b1;
    end else if (w_win_rec) begin
      // Fetch output is still stale from the wrong path: discard it, and
      // hold PC while the refetch itself misses.
      i2d_flush = 1'b1;
      pc_stall  = ic_miss;
    end else if (w_win_lu) begin
      // Hold the consumer in decode and send a bubble into EX.
      pc_stall  = 1'b1;
      i2d_stall = 1'b1;
      d2e_flush = 1'b1;
    end else if (w_win_ic) begin
      pc_stall  = 1'b1;
      i2d_flush = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Recovery FSM
  // --------------------------------------------------------------------------
  // rcnt counts useful (non-missing) fetch cycles still to be discarded.
  // A d-cache miss freezes the FSM because EX (and the branch in it) is held
  // and will be re-evaluated once the miss clears.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;

    if (dc_miss) begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
    end else if (ex_mispredict) begin
      // Also covers a mispredict arriving during RECOVER: reload.
      if (c_has_redir) begin
        state_d = RECOVER;
        rcnt_d  = c_redirect;
      end else begin
        state_d = IDLE;
        rcnt_d  = 4'd0;
      end
    end else if (state_q == RECOVER) begin
      if (!ic_miss) begin
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q <= 4'd1) begin
          state_d = IDLE;
          rcnt_d  = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  // Cycles spent in RECOVER waiting on the i-cache are charged to the
  // i-cache, since the fetch slot would be idle for that reason anyway.
  logic w_inc_dc;
  logic w_inc_mp;
  logic w_inc_lu;
  logic w_inc_ic;

  assign w_inc_dc = w_win_dc;
  assign w_inc_mp = w_win_mp;
  assign w_inc_lu = w_win_lu;
  assign w_inc_ic = w_win_ic | (w_win_rec & ic_miss);

  logic [CNT_W-1:0] cnt_dc_d, cnt_ic_d, cnt_lu_d, cnt_mp_d;

  // Saturating increment; clear dominates.
  function automatic logic [CNT_W-1:0] f_cnt_next(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             clr
  );
    if (clr) begin
      return '0;
    end else if (inc && !(&cur)) begin
      return cur + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return cur;
    end
  endfunction

  always_comb begin
    cnt_dc_d = f_cnt_next(cnt_dc_q, w_inc_dc, clr_cnt);
    cnt_ic_d = f_cnt_next(cnt_ic_q, w_inc_ic, clr_cnt);
    cnt_lu_d = f_cnt_next(cnt_lu_q, w_inc_lu, clr_cnt);
    cnt_mp_d = f_cnt_next(cnt_mp_q, w_inc_mp, clr_cnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_dc_q <= '0;
      cnt_ic_q <= '0;
      cnt_lu_q <= '0;
      cnt_mp_q <= '0;
    end else begin
      cnt_dc_q <= cnt_dc_d;
      cnt_ic_q <= cnt_ic_d;
      cnt_lu_q <= cnt_lu_d;
      cnt_mp_q <= cnt_mp_d;
    end
  end

  assign cnt_dc = cnt_dc_q;
  assign cnt_ic = cnt_ic_q;
  assign cnt_lu = cnt_lu_q;
  assign cnt_mp = cnt_mp_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit
// Purpose  : Directed self-checking bench for hazard_unit (CNT_W = 4,
//            REDIRECT_CYCLES = 2). Stall/flush outputs are packed into a
//            9-bit vector and compared against hand-built constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ic_miss, dc_miss, ex_mispredict, ex_valid, ex_is_load;
  logic [4:0] ex_rw_addr, dec_rs_addr, dec_rt_addr;
  logic dec_valid, dec_uses_rs, dec_uses_rt, clr_cnt;
  logic pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush;
  logic e2m_stall, e2m_flush, m2w_stall, m2w_flush;
  logic [CNT_W-1:0] cnt_dc, cnt_ic, cnt_lu, cnt_mp;

  hazard_unit #(.REDIRECT_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_miss(ic_miss), .dc_miss(dc_miss), .ex_mispredict(ex_mispredict),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rw_addr(ex_rw_addr),
    .dec_valid(dec_valid), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr), .clr_cnt(clr_cnt),
    .pc_stall(pc_stall), .i2d_stall(i2d_stall), .i2d_flush(i2d_flush),
    .d2e_stall(d2e_stall), .d2e_flush(d2e_flush),
    .e2m_stall(e2m_stall), .e2m_flush(e2m_flush),
    .m2w_stall(m2w_stall), .m2w_flush(m2w_flush),
    .cnt_dc(cnt_dc), .cnt_ic(cnt_ic), .cnt_lu(cnt_lu), .cnt_mp(cnt_mp)
  );

  always #5 clk = ~clk;

  // {pc_s, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s, m2w_f}
  logic [8:0] outs;
  assign outs = {pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
                 e2m_stall, e2m_flush, m2w_stall, m2w_flush};

  localparam logic [8:0] O_NONE  = 9'b000_000_000;
  localparam logic [8:0] O_RST   = 9'b001_010_101;
  localparam logic [8:0] O_DC    = 9'b110_101_001;
  localparam logic [8:0] O_MP    = 9'b001_010_000;
  localparam logic [8:0] O_REC   = 9'b001_000_000;
  localparam logic [8:0] O_RECIC = 9'b101_000_000;
  localparam logic [8:0] O_LU    = 9'b110_010_000;
  localparam logic [8:0] O_IC    = 9'b101_000_000;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ic_miss = 0; dc_miss = 0; ex_mispredict = 0;
    ex_valid = 0; ex_is_load = 0; ex_rw_addr = 0;
    dec_valid = 0; dec_uses_rs = 0; dec_uses_rt = 0;
    dec_rs_addr = 0; dec_rt_addr = 0;
  endtask

  task automatic set_lu(input logic [4:0] rw, input logic [4:0] rs);
    ex_valid = 1; ex_is_load = 1; ex_rw_addr = rw;
    dec_valid = 1; dec_uses_rs = 1; dec_rs_addr = rs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clr_in();
    clr_cnt = 0;
    rst_n   = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 32'(outs), 32'(O_RST));
    check("rst_cnt_dc", 32'(cnt_dc), 0);
    check("rst_cnt_mp", 32'(cnt_mp), 0);
    rst_n = 1;
    #1 check("idle_outs", 32'(outs), 32'(O_NONE));

    // Load-use on rs, then the same with destination $zero.
    set_lu(5'd8, 5'd8);
    #1 check("lu_outs", 32'(outs), 32'(O_LU));
    tick(); clr_in();
    #1 check("lu_after", 32'(outs), 32'(O_NONE));
    check("lu_cnt", 32'(cnt_lu), 1);
    set_lu(5'd0, 5'd0);
    #1 check("lu_zero_outs", 32'(outs), 32'(O_NONE));
    tick(); clr_in();
    #1 check("lu_zero_cnt", 32'(cnt_lu), 1);

    // Mispredict + 2-cycle recovery; load-use ignored in RECOVER.
    ex_mispredict = 1;
    #1 check("mp_c0", 32'(outs), 32'(O_MP));
    tick(); ex_mispredict = 0; set_lu(5'd8, 5'd8);
    #1 check("mp_c1", 32'(outs), 32'(O_REC));
    check("mp_cnt", 32'(cnt_mp), 1);
    tick(); clr_in();
    #1 check("mp_c2", 32'(outs), 32'(O_REC));
    tick();
    #1 check("mp_c3", 32'(outs), 32'(O_NONE));
    check("mp_lu_cnt", 32'(cnt_lu), 1);

    // Mispredict with ic_miss during the first recovery cycle.
    ex_mispredict = 1;
    #1 check("mpic_c0", 32'(outs), 32'(O_MP));
    tick(); ex_mispredict = 0; ic_miss = 1;
    #1 check("mpic_c1", 32'(outs), 32'(O_RECIC));
    tick(); ic_miss = 0;
    #1 check("mpic_c2", 32'(outs), 32'(O_REC));
    check("mpic_cnt_ic", 32'(cnt_ic), 1);
    tick();
    #1 check("mpic_c3", 32'(outs), 32'(O_REC));
    tick();
    #1 check("mpic_c4", 32'(outs), 32'(O_NONE));
    check("mpic_cnt_mp", 32'(cnt_mp), 2);

    // dc_miss beats mispredict and load-use for 3 cycles.
    dc_miss = 1; ex_mispredict = 1; set_lu(5'd8, 5'd8);
    for (int i = 0; i < 3; i++) begin
      #1 check("dc_outs", 32'(outs), 32'(O_DC));
      tick();
    end
    dc_miss = 0;
    #1 check("dc_then_mp", 32'(outs), 32'(O_MP));
    check("dc_cnt_dc", 32'(cnt_dc), 3);
    check("dc_cnt_mp", 32'(cnt_mp), 2);
    check("dc_cnt_lu", 32'(cnt_lu), 1);
    tick(); clr_in();
    #1 check("dc_rec1", 32'(outs), 32'(O_REC));
    check("dc_cnt_mp2", 32'(cnt_mp), 3);
    tick();
    #1 check("dc_rec2", 32'(outs), 32'(O_REC));
    tick();
    #1 check("dc_idle", 32'(outs), 32'(O_NONE));

    // ic_miss alone.
    ic_miss = 1;
    #1 check("ic_outs", 32'(outs), 32'(O_IC));
    tick(); ic_miss = 0;
    #1 check("ic_cnt", 32'(cnt_ic), 2);

    // Mispredict on the last recovery cycle reloads rcnt.
    ex_mispredict = 1;
    #1 check("last_c0", 32'(outs), 32'(O_MP));
    tick(); ex_mispredict = 0;
    #1 check("last_c1", 32'(outs), 32'(O_REC));
    tick(); ex_mispredict = 1;
    #1 check("last_c2", 32'(outs), 32'(O_MP));
    tick(); ex_mispredict = 0;
    #1 check("last_c3", 32'(outs), 32'(O_REC));
    tick();
    #1 check("last_c4", 32'(outs), 32'(O_REC));
    tick();
    #1 check("last_c5", 32'(outs), 32'(O_NONE));
    check("last_cnt_mp", 32'(cnt_mp), 5);

    // Saturation and clear-over-increment.
    dc_miss = 1;
    repeat (20) tick();
    check("sat_cnt_dc", 32'(cnt_dc), 15);
    clr_cnt = 1;
    tick(); clr_cnt = 0;
    check("clr_cnt_dc", 32'(cnt_dc), 0);
    check("clr_cnt_mp", 32'(cnt_mp), 0);
    check("clr_cnt_ic", 32'(cnt_ic), 0);
    dc_miss = 0;

    // Reset in the middle of recovery.
    tick(); ex_mispredict = 1;
    tick(); ex_mispredict = 0;
    #1 check("rrec_c1", 32'(outs), 32'(O_REC));
    rst_n = 0;
    #1 check("rrec_rst_outs", 32'(outs), 32'(O_RST));
    tick(); rst_n = 1;
    #1 check("rrec_idle", 32'(outs), 32'(O_NONE));
    check("rrec_cnt_mp", 32'(cnt_mp), 0);
    check("rrec_cnt_dc", 32'(cnt_dc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
